shift_seq: RTL and testbench
============================

Name: shift_seq

Overview:
- Multi-cycle shift/rotate engine for the 16-bit execute datapath. Handles ROL, SLL, ROR and SRA by shifting one bit per cycle.
- Only left shifts are performed internally. Right-direction ops are built as bit-reverse, left-shift with the correct fill, then bit-reverse again.
- A single shared 16-bit bit-reversal unit is time-multiplexed between the pre-reverse and post-reverse steps.
- Sits beside the ALU. It is driven by a start/done handshake from the execute-stage control.

Parameters:
- none. Datapath width is fixed at 16 bits to match the 16-bit bit-reversal unit. The shift count is fixed at 4 bits.

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy=0
op  input  2  00=ROL, 01=SLL, 10=ROR, 11=SRA
amt  input  4  shift amount, 0..15
in  input  16  operand
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; result is valid in that cycle
result  output  16  last completed result; held until the next completion

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, done=0, result=16'h0000, internal data/count/op registers cleared.
- States: IDLE, SHIFT, FIN. busy = (state != IDLE), decoded from the state register.
- IDLE:
  - When start=1, capture op and amt, and load cnt=amt.
  - Load data = reverse(in) if op[1]=1, else in.
  - Load fill = in[15] if op=SRA, else 0.
  - Next state is SHIFT. When start=0, remain in IDLE.
- SHIFT:
  - If cnt==0, go to FIN.
  - Else shift data left by 1 and decrement cnt. The new bit 0 is:
    - ROL/ROR: old data[15];
    - SLL: 0;
    - SRA: fill.
- FIN:
  - result <= reverse(data) if op[1]=1, else data.
  - done <= 1 (registered), then go to IDLE.
- done is high in the first IDLE cycle after FIN and low otherwise.
- Latency: start high in cycle 0 gives busy high in cycles 1..amt+2 and done high in cycle amt+3. For amt=0, done is high in cycle 3 and result equals in for every op.
- Shared resource: exactly one bit-reversal instance.
  - Its input mux selects `in` in IDLE and `data` in FIN.
  - Its output is don't-care in SHIFT.
  - No second reversal instance is permitted.
- start while busy=1: ignored, with no queuing.
- Changes to op, amt or in while busy: ignored, because operands are captured at acceptance.
- start in the done cycle (state is IDLE): accepted normally. done still pulses for the prior operation.
- result changes only in the cycle done is high, or on reset.
- rst mid-operation: return to IDLE next cycle, clear result, and produce no done pulse. The aborted op is lost.
- rst and start in the same cycle: rst wins; start is not accepted.
- No arithmetic beyond the 4-bit down-counter. cnt never underflows, because the zero check precedes the decrement.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 -> busy=0, done=0, result=16'h0000. Nothing is accepted while rst=1.
- SRA in=16'h8001, amt=1 -> done in cycle 4, result=16'hC000. Also SRA in=16'h4000, amt=15 -> result=16'h0000 with done in cycle 18.
- ROR in=16'h0001, amt=4 -> result=16'h1000. ROL in=16'h8001, amt=1 -> result=16'h0003.
- SLL in=16'h00FF, amt=8 -> result=16'hFF00, done high in cycle 11. amt=0 with any op and in=16'hA5C3 -> result=16'hA5C3, done in cycle 3.
- Start/operand changes while busy:
  - Start ROR 16'h0001, amt=4. Pulse start with op=SLL, in=16'hFFFF in cycle 2, and change in during busy.
  - Required: a single done with result=16'h1000 and no second operation.
  - Back-to-back: assert the next start in the done cycle -> accepted, busy high the next cycle.
- Abort: start SLL in=16'h0001, amt=10, then assert rst in cycle 5 -> busy=0 from cycle 6, no done pulse, result=16'h0000.

Source files
------------

// File: rtl/shift_seq.sv
// Multi-cycle 16-bit shift/rotate engine (ROL, SLL, ROR, SRA), one bit per cycle.
// Right-direction ops run as reverse -> left shift -> reverse through one shared reversal unit.
module shift_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [3:0]  amt,
    input  logic [15:0] in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result
);

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRA = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        FIN   = 2'b10
    } state_e;

    state_e      state, state_n;
    op_e         op_q, op_n;
    logic [15:0] data, data_n;
    logic [3:0]  cnt, cnt_n;
    logic        fill, fill_n;
    logic [15:0] result_n;
    logic        done_n;

    logic [15:0] rev_in, rev_out;
    logic        shift_bit;

    // Single reversal unit: operand on the way in, shifted data on the way out.
    assign rev_in = (state == FIN) ? data : in;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            rev_out[i] = rev_in[15-i];
        end
    end

    always_comb begin
        case (op_q)
            OP_SLL:  shift_bit = 1'b0;
            OP_SRA:  shift_bit = fill;
            default: shift_bit = data[15];
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a variable unassigned and infer a latch.
        state_n  = state;
        op_n     = op_q;
        data_n   = data;
        cnt_n    = cnt;
        fill_n   = fill;
        result_n = result;
        done_n   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    op_n    = op_e'(op);
                    cnt_n   = amt;
                    data_n  = op[1] ? rev_out : in;
                    fill_n  = (op == OP_SRA) ? in[15] : 1'b0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                // Zero test comes before the decrement, so cnt never wraps.
                if (cnt == 4'd0) begin
                    state_n = FIN;
                end else begin
                    data_n = {data[14:0], shift_bit};
                    cnt_n  = cnt - 4'd1;
                end
            end
            FIN: begin
                result_n = op_q[1] ? rev_out : data;
                done_n   = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state  <= IDLE;
            op_q   <= OP_ROL;
            data   <= 16'h0000;
            cnt    <= 4'd0;
            fill   <= 1'b0;
            result <= 16'h0000;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            op_q   <= op_n;
            data   <= data_n;
            cnt    <= cnt_n;
            fill   <= fill_n;
            result <= result_n;
            done   <= done_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: reset, each op, amt boundaries, busy-time
// stimulus, back-to-back start and mid-operation reset.
module tb_shift_seq;

    localparam logic [1:0] ROL = 2'b00;
    localparam logic [1:0] SLL = 2'b01;
    localparam logic [1:0] ROR = 2'b10;
    localparam logic [1:0] SRA = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [3:0]  amt = 4'd0;
    logic [15:0] in = 16'h0000;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int pass_cnt  = 0;
    int total_cnt = 0;

    shift_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .amt    (amt),
        .in     (in),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle (cycle 0) and wait for done.
    // done_cyc is the cycle number in which done was seen, -1 if never.
    task automatic run_op(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d,
                          output int done_cyc, output logic [15:0] res, output bit busy_ok);
        done_cyc = -1;
        res      = 16'hxxxx;
        busy_ok  = 1'b1;
        op    = o;
        amt   = a;
        in    = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (done === 1'b1) begin
                done_cyc = c;
                res      = result;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        op    = SLL;
        amt   = 4'd1;
        in    = 16'hFFFF;
        tick();
        tick();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done);
        else pass_cnt++;
        total_cnt++;
        if (result !== 16'h0000) $display("FAIL reset_result: got %h want 0000", result);
        else pass_cnt++;
        rst   = 1'b0;
        start = 1'b0;
        tick();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_no_accept: busy got %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_sra();
        int dc; logic [15:0] r; bit bok;
        run_op(SRA, 4'd1, 16'h8001, dc, r, bok);
        total_cnt++;
        if (dc != 4) $display("FAIL sra1_done_cycle: got %0d want 4", dc);
        else pass_cnt++;
        total_cnt++;
        if (r !== 16'hC000) $display("FAIL sra1_result: got %h want c000", r);
        else pass_cnt++;
        total_cnt++;
        if (!bok) $display("FAIL sra1_busy: busy profile wrong, got 0 want 1");
        else pass_cnt++;
        tick();
        run_op(SRA, 4'd15, 16'h4000, dc, r, bok);
        total_cnt++;
        if (dc != 18) $display("FAIL sra15_done_cycle: got %0d want 18", dc);
        else pass_cnt++;
        total_cnt++;
        if (r !== 16'h0000) $display("FAIL sra15_result: got %h want 0000", r);
        else pass_cnt++;
        total_cnt++;
        if (!bok) $display("FAIL sra15_busy: busy profile wrong, got 0 want 1");
        else pass_cnt++;
        tick();
    endtask

    task automatic test_rotate();
        int dc; logic [15:0] r; bit bok;
        run_op(ROR, 4'd4, 16'h0001, dc, r, bok);
        total_cnt++;
        if (r !== 16'h1000) $display("FAIL ror4_result: got %h want 1000", r);
        else pass_cnt++;
        total_cnt++;
        if (dc != 7) $display("FAIL ror4_done_cycle: got %0d want 7", dc);
        else pass_cnt++;
        tick();
        run_op(ROL, 4'd1, 16'h8001, dc, r, bok);
        total_cnt++;
        if (r !== 16'h0003) $display("FAIL rol1_result: got %h want 0003", r);
        else pass_cnt++;
        total_cnt++;
        if (dc != 4) $display("FAIL rol1_done_cycle: got %0d want 4", dc);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (result !== 16'h0003) $display("FAIL rol1_held: got %h want 0003", result);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL rol1_single_pulse: done got %b want 0", done);
        else pass_cnt++;
    endtask

    task automatic test_sll();
        int dc; logic [15:0] r; bit bok;
        logic [1:0] ops [4] = '{ROL, SLL, ROR, SRA};
        run_op(SLL, 4'd8, 16'h00FF, dc, r, bok);
        total_cnt++;
        if (r !== 16'hFF00) $display("FAIL sll8_result: got %h want ff00", r);
        else pass_cnt++;
        total_cnt++;
        if (dc != 11) $display("FAIL sll8_done_cycle: got %0d want 11", dc);
        else pass_cnt++;
        tick();
        foreach (ops[i]) begin
            run_op(ops[i], 4'd0, 16'hA5C3, dc, r, bok);
            total_cnt++;
            if (r !== 16'hA5C3) $display("FAIL amt0_op%0d_result: got %h want a5c3", i, r);
            else pass_cnt++;
            total_cnt++;
            if (dc != 3) $display("FAIL amt0_op%0d_done_cycle: got %0d want 3", i, dc);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_busy_ignore();
        int dc = -1;
        int extra_done = 0;
        int extra_busy = 0;
        logic [15:0] r = 16'hxxxx;
        op    = ROR;
        amt   = 4'd4;
        in    = 16'h0001;
        start = 1'b1;
        tick();                       // cycle 1
        start = 1'b0;
        tick();                       // cycle 2
        op    = SLL;
        in    = 16'hFFFF;
        start = 1'b1;
        tick();                       // cycle 3
        start = 1'b0;
        in    = 16'h1234;
        amt   = 4'd9;
        for (int c = 3; c <= 40; c++) begin
            if (done === 1'b1) begin
                dc = c;
                r  = result;
                break;
            end
            tick();
        end
        total_cnt++;
        if (dc != 7) $display("FAIL busy_ignore_done_cycle: got %0d want 7", dc);
        else pass_cnt++;
        total_cnt++;
        if (r !== 16'h1000) $display("FAIL busy_ignore_result: got %h want 1000", r);
        else pass_cnt++;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (done === 1'b1) extra_done++;
            if (busy !== 1'b0) extra_busy++;
        end
        total_cnt++;
        if (extra_done != 0) $display("FAIL busy_ignore_second_done: got %0d want 0", extra_done);
        else pass_cnt++;
        total_cnt++;
        if (extra_busy != 0) $display("FAIL busy_ignore_second_op: busy cycles got %0d want 0", extra_busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int dc; logic [15:0] r; bit bok;
        run_op(SLL, 4'd2, 16'h0001, dc, r, bok);
        total_cnt++;
        if (r !== 16'h0004) $display("FAIL b2b_first_result: got %h want 0004", r);
        else pass_cnt++;
        total_cnt++;
        if (dc != 5) $display("FAIL b2b_first_done_cycle: got %0d want 5", dc);
        else pass_cnt++;
        // Still in the done cycle: start the next op right away.
        run_op(ROL, 4'd1, 16'h8001, dc, r, bok);
        total_cnt++;
        if (!bok) $display("FAIL b2b_second_busy: busy profile wrong, got 0 want 1");
        else pass_cnt++;
        total_cnt++;
        if (dc != 4) $display("FAIL b2b_second_done_cycle: got %0d want 4", dc);
        else pass_cnt++;
        total_cnt++;
        if (r !== 16'h0003) $display("FAIL b2b_second_result: got %h want 0003", r);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_abort();
        int seen_done = 0;
        op    = SLL;
        amt   = 4'd10;
        in    = 16'h0001;
        start = 1'b1;
        tick();                       // cycle 1
        start = 1'b0;
        for (int c = 1; c < 5; c++) begin
            if (done === 1'b1) seen_done++;
            tick();
        end                           // now cycle 5
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy);
        else pass_cnt++;
        rst = 1'b1;
        tick();                       // cycle 6
        rst = 1'b0;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (result !== 16'h0000) $display("FAIL abort_result: got %h want 0000", result);
        else pass_cnt++;
        for (int c = 0; c < 15; c++) begin
            if (done === 1'b1) seen_done++;
            tick();
        end
        total_cnt++;
        if (seen_done != 0) $display("FAIL abort_done: got %0d pulses want 0", seen_done);
        else pass_cnt++;
        total_cnt++;
        if (result !== 16'h0000) $display("FAIL abort_result_held: got %h want 0000", result);
        else pass_cnt++;
    endtask

    initial begin
        tick();
        test_reset();
        test_sra();
        test_rotate();
        test_sll();
        test_busy_ignore();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
